// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: request/response
// structs exchanged with the core, the responder FSM state type and
// small byte-lane helpers used by the responder datapath.
package dmem_responder_pkg;

    // Request from the core to the memory.
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    // Response from the memory to the core.
    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    // Responder FSM: waiting for a request, counting down latency, presenting a response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Latency counter width; holds latency values up to 15.
    localparam int unsigned cnt_width_lp = 4;

    // One-hot byte-write mask for a single byte lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    // Select one byte lane of a word and zero-extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] lane_byte;
        case (lane)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            default: lane_byte = word[31:24];
        endcase
        return {24'h0, lane_byte};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage for the data-memory responder: asynchronous read,
// synchronous write with a per-byte write mask. Contents are never reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    w_en_i,
    input  logic [3:0]              w_mask_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [31:0]             w_data_i,
    output logic [31:0]             r_data_o
);

    localparam int unsigned depth_lp = 1 << addr_width_p;

    logic [31:0] storage [depth_lp];

    // Read path is purely combinational so the responder can sample it on the accept edge.
    always_comb begin
        r_data_o = storage[addr_i];
    end

    // Byte-masked write; unmasked lanes keep their previous contents.
    always_ff @(posedge clk) begin
        if (w_en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mask_i[i]) begin
                    storage[addr_i][8*i +: 8] <= w_data_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time from the core,
// performs the store or samples the load on the accept edge, waits
// latency_p cycles and then holds the response until the core takes it.
// Optional feature: define DMEM_RANGE_CHECK_EN to reject requests whose
// address has bits set above the stored range and raise a sticky error_o.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o,
    output logic        error_o
);

    localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);
    localparam logic [cnt_width_lp-1:0] cnt_load_lp = cnt_width_lp'(latency_p - 1);

    dmem_state_e              state_q, state_d;
    logic [cnt_width_lp-1:0]  cnt_q, cnt_d;
    logic [31:0]              data_q, data_d;
    logic [1:0]               lane_q, lane_d;
    logic                     wen_q, wen_d;
    logic                     bnw_q, bnw_d;
    logic                     oor_q, oor_d;

    logic                     accept;
    logic                     out_of_range;
    logic [addr_width_p-1:0]  word_idx;
    logic [1:0]               lane;
    logic                     mem_w_en;
    logic [3:0]               mem_w_mask;
    logic [31:0]              mem_w_data;
    logic [31:0]              mem_r_data;
    logic [31:0]              resp_data;

    assign word_idx = addr_i[addr_width_p+1:2];
    assign lane     = addr_i[1:0];

`ifdef DMEM_RANGE_CHECK_EN
    // Any address bit above the stored word range marks the request as out of range.
    always_comb begin
        out_of_range = |addr_i[31:addr_width_p+2];
    end
`else
    logic addr_hi_unused;

    // Upper address bits are ignored, so addresses simply wrap around the array.
    always_comb begin
        addr_hi_unused = |addr_i[31:addr_width_p+2];
        out_of_range   = 1'b0;
    end
`endif

    // A request is taken only in IDLE and never while reset is held.
    always_comb begin
        accept = (state_q == IDLE) && to_mem_i.valid && !reset;
    end

    // Store path: a byte store replicates the low byte and enables one lane, a word store all four.
    always_comb begin
        mem_w_en   = accept && to_mem_i.wen && !out_of_range;
        mem_w_mask = to_mem_i.byte_not_word ? lane_mask(lane) : 4'hF;
        mem_w_data = to_mem_i.byte_not_word ? {4{to_mem_i.write_data[7:0]}} : to_mem_i.write_data;
    end

    dmem_array #(
        .addr_width_p (addr_width_p)
    ) u_array (
        .clk      (clk),
        .w_en_i   (mem_w_en),
        .w_mask_i (mem_w_mask),
        .addr_i   (word_idx),
        .w_data_i (mem_w_data),
        .r_data_o (mem_r_data)
    );

    // Next-state logic: latch the request on accept, count down latency, retire on yumi.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        lane_d  = lane_q;
        wen_d   = wen_q;
        bnw_d   = bnw_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    lane_d = lane;
                    wen_d  = to_mem_i.wen;
                    bnw_d  = to_mem_i.byte_not_word;
                    oor_d  = out_of_range;
                    data_d = to_mem_i.wen ? to_mem_i.write_data : mem_r_data;
                    if (latency_p == 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = cnt_load_lp;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - cnt_one_lp;
                if (cnt_q == cnt_one_lp) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (to_mem_i.yumi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and request latch; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        data_q <= data_d;
        lane_q <= lane_d;
        wen_q  <= wen_d;
        bnw_q  <= bnw_d;
        oor_q  <= oor_d;
    end

    // Response data: stores and rejected requests return zero, byte loads a zero-extended lane.
    always_comb begin
        if (wen_q || oor_q) begin
            resp_data = 32'h0;
        end else if (bnw_q) begin
            resp_data = lane_extract(data_q, lane_q);
        end else begin
            resp_data = data_q;
        end
    end

    // Outputs to the core, forced to zero while reset is asserted.
    always_comb begin
        from_mem_o = '0;
        if (!reset) begin
            from_mem_o.yumi  = accept;
            from_mem_o.valid = (state_q == RESP);
            if (state_q == RESP) begin
                from_mem_o.read_data = resp_data;
            end
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q, err_d;

    // Error flag is set by any accepted out-of-range request and held until reset.
    always_comb begin
        err_d = err_q | (accept & out_of_range);
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error_o = err_q & ~reset;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// randomized traffic, all checked against a word-array model of the memory.
// Builds with or without DMEM_RANGE_CHECK_EN; the model follows the same macro.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    mem_in_s     to_mem;
    logic [31:0] addr;
    mem_out_s    from_mem;
    logic        err;

    mem_in_s     to_mem_l1;
    logic [31:0] addr_l1;
    mem_out_s    from_mem_l1;
    logic        err_l1;

    int compared   = 0;
    int mismatched = 0;

    // Reference memory contents and expected error flag.
    logic [31:0] model [1024];
    bit          exp_err = 1'b0;

    logic [31:0] rd, exp_v, exp_v2, first;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    dmem_responder #(
        .addr_width_p (10),
        .latency_p    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .to_mem_i   (to_mem),
        .addr_i     (addr),
        .from_mem_o (from_mem),
        .error_o    (err)
    );

    dmem_responder #(
        .addr_width_p (10),
        .latency_p    (1)
    ) dut_l1 (
        .clk        (clk),
        .reset      (reset),
        .to_mem_i   (to_mem_l1),
        .addr_i     (addr_l1),
        .from_mem_o (from_mem_l1),
        .error_o    (err_l1)
    );

    // One comparison: counted, asserted, and reported on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Memory model: applies a request to the word array and yields the expected read_data.
    task automatic modelAccess(input logic [31:0] a, input logic w, input logic b,
                               input logic [31:0] wd, output logic [31:0] expv);
        int unsigned idx = (a >> 2) % 1024;
        int unsigned sh  = (a % 4) * 8;
        bit          oor = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        oor = (a >= 32'h1000);
`endif
        expv = 32'h0;
        if (oor) begin
            exp_err = 1'b1;
        end else if (w) begin
            if (b) model[idx] = (model[idx] & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
            else   model[idx] = wd;
        end else if (b) begin
            expv = (model[idx] >> sh) & 32'hFF;
        end else begin
            expv = model[idx];
        end
    endtask

    // Full transaction on the latency-2 instance, with junk on ignored inputs while busy.
    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic b,
                                 input logic [31:0] wd, input int hold, output logic [31:0] rdo);
        int          lat;
        logic [31:0] expv, held;
        @(negedge clk);
        addr                  = a;
        to_mem.valid          = 1'b1;
        to_mem.wen            = w;
        to_mem.byte_not_word  = b;
        to_mem.write_data     = wd;
        to_mem.yumi           = 1'b0;
        modelAccess(a, w, b, wd, expv);
        #1 checkOutput("accept_yumi", 32'(from_mem.yumi), 32'd1);
        @(posedge clk);
        #1;
        to_mem.valid      = $urandom_range(0, 1);
        to_mem.wen        = $urandom_range(0, 1);
        to_mem.write_data = $urandom;
        to_mem.yumi       = 1'b1;
        addr              = $urandom;
        lat = 1;
        @(negedge clk);
        while (from_mem.valid !== 1'b1 && lat < 40) begin
            checkOutput("busy_yumi", 32'(from_mem.yumi), 32'd0);
            @(negedge clk);
            lat++;
        end
        to_mem.yumi  = 1'b0;
        to_mem.valid = 1'b0;
        checkOutput("latency", 32'(lat), 32'd2);
        checkOutput("read_data", from_mem.read_data, expv);
        checkOutput("error_o", 32'(err), 32'(exp_err));
        held = from_mem.read_data;
        rdo  = held;
        repeat (hold) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(from_mem.valid), 32'd1);
            checkOutput("hold_data", from_mem.read_data, held);
        end
        to_mem.yumi = 1'b1;
        @(posedge clk);
        #1 to_mem.yumi = 1'b0;
        checkOutput("retired", 32'(from_mem.valid), 32'd0);
    endtask

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        reset        = 1'b1;
        to_mem       = '0;
        to_mem.valid = 1'b1;
        addr         = 32'h0;
        to_mem_l1    = '0;
        addr_l1      = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst_valid", 32'(from_mem.valid), 32'd0);
        checkOutput("rst_yumi", 32'(from_mem.yumi), 32'd0);
        checkOutput("rst_data", from_mem.read_data, 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        to_mem.valid = 1'b0;
        checkOutput("post_rst_valid", 32'(from_mem.valid), 32'd0);

        // Give every word the traffic can touch a known value.
        for (int i = 0; i < 64; i++) begin
            applyStimulus(32'(i * 4), 1'b1, 1'b0, $urandom, 0, rd);
        end

        // Word store then word load.
        applyStimulus(32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 0, rd);
        checkOutput("store_rdata_zero", rd, 32'h0);
        applyStimulus(32'h10, 1'b0, 1'b0, 32'h0, 0, rd);
        checkOutput("word_load", rd, 32'hDEADBEEF);

        // Byte store into one lane, then byte and word loads.
        applyStimulus(32'h10, 1'b1, 1'b0, 32'h11223344, 0, rd);
        applyStimulus(32'h13, 1'b1, 1'b1, 32'hFFFFFFAB, 0, rd);
        applyStimulus(32'h13, 1'b0, 1'b1, 32'h0, 0, rd);
        checkOutput("byte_load", rd, 32'h000000AB);
        applyStimulus(32'h10, 1'b0, 1'b0, 32'h0, 0, rd);
        checkOutput("word_after_byte", rd, 32'hAB223344);
        applyStimulus(32'h12, 1'b0, 1'b0, 32'h0, 0, rd);
        checkOutput("word_ignores_lane", rd, 32'hAB223344);

        // Backpressure: response held for 5 cycles, no accept in the retire cycle.
        @(negedge clk);
        addr = 32'h10;
        to_mem.valid = 1'b1;
        to_mem.wen = 1'b0;
        to_mem.byte_not_word = 1'b0;
        to_mem.yumi = 1'b0;
        modelAccess(32'h10, 1'b0, 1'b0, 32'h0, exp_v);
        #1 checkOutput("bp_accept", 32'(from_mem.yumi), 32'd1);
        @(posedge clk);
        #1 to_mem.valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("bp_valid", 32'(from_mem.valid), 32'd1);
        checkOutput("bp_data", from_mem.read_data, exp_v);
        first = from_mem.read_data;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(from_mem.valid), 32'd1);
            checkOutput("bp_hold_data", from_mem.read_data, first);
        end
        to_mem.yumi = 1'b1;
        to_mem.valid = 1'b1;
        to_mem.byte_not_word = 1'b1;
        addr = 32'h13;
        #1 checkOutput("bp_no_accept_retire", 32'(from_mem.yumi), 32'd0);
        @(posedge clk);
        #1 to_mem.yumi = 1'b0;
        checkOutput("bp_idle", 32'(from_mem.valid), 32'd0);
        checkOutput("bp_accept_next", 32'(from_mem.yumi), 32'd1);
        modelAccess(32'h13, 1'b0, 1'b1, 32'h0, exp_v2);
        @(posedge clk);
        #1 to_mem.valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("bp_next_valid", 32'(from_mem.valid), 32'd1);
        checkOutput("bp_next_data", from_mem.read_data, exp_v2);
        to_mem.yumi = 1'b1;
        @(posedge clk);
        #1 to_mem.yumi = 1'b0;
        to_mem.byte_not_word = 1'b0;

        // Reset while busy after a store: no response, store survives.
        @(negedge clk);
        addr = 32'h20;
        to_mem.valid = 1'b1;
        to_mem.wen = 1'b1;
        to_mem.write_data = 32'h5;
        modelAccess(32'h20, 1'b1, 1'b0, 32'h5, exp_v);
        #1 checkOutput("rb_accept", 32'(from_mem.yumi), 32'd1);
        @(posedge clk);
        #1 to_mem.valid = 1'b0;
        to_mem.wen = 1'b0;
        reset = 1'b1;
        exp_err = 1'b0;
        #1 checkOutput("rb_valid_in_rst", 32'(from_mem.valid), 32'd0);
        checkOutput("rb_err_in_rst", 32'(err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("rb_no_resp", 32'(from_mem.valid), 32'd0);
        end
        applyStimulus(32'h20, 1'b0, 1'b0, 32'h0, 0, rd);
        checkOutput("rb_store_kept", rd, 32'h5);

        // Out-of-range store: rejected with error when checked, otherwise wraps to word 0.
        checkOutput("err_before_range", 32'(err), 32'd0);
        applyStimulus(32'h00001000, 1'b1, 1'b0, 32'hCAFEF00D, 1, rd);
        checkOutput("range_store_rdata", rd, 32'h0);
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 0, rd);
`ifdef DMEM_RANGE_CHECK_EN
        checkOutput("range_err_sticky", 32'(err), 32'd1);
`else
        checkOutput("range_wrap_word0", rd, 32'hCAFEF00D);
        checkOutput("range_err_tied", 32'(err), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        exp_err = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("err_cleared", 32'(err), 32'd0);

        // Minimum latency instance: response valid in the cycle after accept.
        @(negedge clk);
        addr_l1 = 32'h0;
        to_mem_l1.valid = 1'b1;
        to_mem_l1.wen = 1'b1;
        to_mem_l1.write_data = 32'h0BADC0DE;
        #1 checkOutput("l1_store_accept", 32'(from_mem_l1.yumi), 32'd1);
        @(posedge clk);
        #1 to_mem_l1.valid = 1'b0;
        to_mem_l1.wen = 1'b0;
        checkOutput("l1_store_valid", 32'(from_mem_l1.valid), 32'd1);
        checkOutput("l1_store_data", from_mem_l1.read_data, 32'h0);
        to_mem_l1.yumi = 1'b1;
        @(posedge clk);
        #1 to_mem_l1.yumi = 1'b0;
        @(negedge clk);
        to_mem_l1.valid = 1'b1;
        #1 checkOutput("l1_load_accept", 32'(from_mem_l1.yumi), 32'd1);
        @(posedge clk);
        #1 to_mem_l1.valid = 1'b0;
        checkOutput("l1_load_valid", 32'(from_mem_l1.valid), 32'd1);
        checkOutput("l1_load_data", from_mem_l1.read_data, 32'h0BADC0DE);
        checkOutput("l1_err", 32'(err_l1), 32'd0);
        to_mem_l1.yumi = 1'b1;
        @(posedge clk);
        #1 to_mem_l1.yumi = 1'b0;

        // Randomized traffic over the low 64 words, occasionally with upper address bits set.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra;
            ra = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = ra | (32'h1000 << $urandom_range(0, 19));
            applyStimulus(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, $urandom_range(0, 3), rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
